// File: rtl/sr_flip_flop.sv
// Parameterised bank of independent, clocked SR flip-flops with configurable s=r=1 action,
// asynchronous active-high reset and a per-bit registered s=r=1 flag.
`timescale 1ns/1ps

module sr_flip_flop #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter int unsigned      SR11_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] err
);

    // Out-of-range modes collapse to hold
    localparam logic [1:0] MODE = (SR11_MODE <= 32'd3) ? 2'(SR11_MODE) : 2'd0;

    logic [WIDTH-1:0] q_next;

    // Per-bit next-state selection
    always_comb begin
        q_next = q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({s[i], r[i]})
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                2'b11: begin
                    case (MODE)
                        2'd1:    q_next[i] = 1'b0;
                        2'd2:    q_next[i] = 1'b1;
                        2'd3:    q_next[i] = ~q[i];
                        default: q_next[i] = q[i];
                    endcase
                end
                default: q_next[i] = q[i];
            endcase
        end
    end

    // qbar is registered from the same next value so it is never equal to q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            qbar <= ~RST_VAL;
            err  <= '0;
        end else begin
            q    <= q_next;
            qbar <= ~q_next;
            err  <= s & r;
        end
    end

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed self-checking bench for sr_flip_flop: one 1-bit instance per s=r=1 mode
// (plus an out-of-range mode) sharing stimulus, and a 4-bit instance.
`timescale 1ns/1ps

module tb_sr_flip_flop;

    logic       clk;
    logic       rst;
    logic       s;
    logic       r;
    logic [4:0] q_m;
    logic [4:0] qb_m;
    logic [4:0] e_m;

    logic       rst4;
    logic [3:0] s4;
    logic [3:0] r4;
    logic [3:0] q4;
    logic [3:0] qb4;
    logic [3:0] e4;

    int n_checks;
    int n_fail;

    localparam int unsigned MODES [5] = '{0, 1, 2, 3, 7};

    // Bit k of q_m/qb_m/e_m belongs to the instance with SR11_MODE = MODES[k]
    for (genvar k = 0; k < 5; k++) begin : g_m
        sr_flip_flop #(
            .WIDTH    (1),
            .RST_VAL  (1'b0),
            .SR11_MODE(MODES[k])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .s   (s),
            .r   (r),
            .q   (q_m[k]),
            .qbar(qb_m[k]),
            .err (e_m[k])
        );
    end

    sr_flip_flop #(
        .WIDTH    (4),
        .RST_VAL  (4'b1010),
        .SR11_MODE(0)
    ) u_w4 (
        .clk (clk),
        .rst (rst4),
        .s   (s4),
        .r   (r4),
        .q   (q4),
        .qbar(qb4),
        .err (e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic [4:0] qe, input logic [4:0] ee);
        n_checks++;
        if (q_m !== qe) begin
            n_fail++;
            $display("FAIL %s q: got %b expected %b", name, q_m, qe);
        end
        n_checks++;
        if (qb_m !== ~qe) begin
            n_fail++;
            $display("FAIL %s qbar: got %b expected %b", name, qb_m, ~qe);
        end
        n_checks++;
        if (e_m !== ee) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", name, e_m, ee);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("reset_async", 5'b00000, 5'b00000);
        s = 1'b1;
        r = 1'b0;
        @(posedge clk);
        #1;
        chk1("reset_ignores_clock", 5'b00000, 5'b00000);
    endtask

    task automatic test_hold_reset();
        @(negedge clk);
        rst = 1'b0;
        s   = 1'b0;
        r   = 1'b0;
        @(posedge clk);
        #1;
        chk1("hold_00", 5'b00000, 5'b00000);
        @(negedge clk);
        r = 1'b1;
        @(posedge clk);
        #1;
        chk1("reset_01", 5'b00000, 5'b00000);
    endtask

    task automatic test_set_hold();
        @(negedge clk);
        s = 1'b1;
        r = 1'b0;
        @(posedge clk);
        #1;
        chk1("set_10", 5'b11111, 5'b00000);
        @(negedge clk);
        s = 1'b0;
        @(posedge clk);
        #1;
        chk1("hold_after_set", 5'b11111, 5'b00000);
    endtask

    // Bits: [4]=mode7(hold) [3]=toggle [2]=force set [1]=force reset [0]=hold
    task automatic test_invalid();
        @(negedge clk);
        s = 1'b1;
        r = 1'b1;
        @(posedge clk);
        #1;
        chk1("sr11_edge1", 5'b10101, 5'b11111);
        @(posedge clk);
        #1;
        chk1("sr11_edge2", 5'b11101, 5'b11111);
        @(negedge clk);
        s = 1'b0;
        r = 1'b0;
        @(posedge clk);
        #1;
        chk1("sr11_exit", 5'b11101, 5'b00000);
    endtask

    task automatic test_async_mid();
        @(negedge clk);
        s = 1'b1;
        r = 1'b0;
        @(posedge clk);
        #1;
        chk1("async_pre_set", 5'b11111, 5'b00000);
        #1;
        rst = 1'b1;
        #1;
        chk1("async_pulse", 5'b00000, 5'b00000);
        #1;
        rst = 1'b0;
        #4;
        chk1("async_after_release", 5'b00000, 5'b00000);
        @(posedge clk);
        #1;
        chk1("async_first_update", 5'b11111, 5'b00000);
    endtask

    task automatic test_multi_bit();
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        n_checks++;
        if (q4 !== 4'b1010 || qb4 !== 4'b0101 || e4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL w4_reset: got q=%b qbar=%b err=%b expected q=1010 qbar=0101 err=0000", q4, qb4, e4);
        end
        @(negedge clk);
        rst4 = 1'b0;
        s4   = 4'b0101;
        r4   = 4'b1010;
        @(posedge clk);
        #1;
        n_checks++;
        if (q4 !== 4'b0101 || qb4 !== 4'b1010 || e4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL w4_update: got q=%b qbar=%b err=%b expected q=0101 qbar=1010 err=0000", q4, qb4, e4);
        end
        @(negedge clk);
        s4 = 4'b0011;
        r4 = 4'b0011;
        @(posedge clk);
        #1;
        n_checks++;
        if (q4 !== 4'b0101 || qb4 !== 4'b1010 || e4 !== 4'b0011) begin
            n_fail++;
            $display("FAIL w4_sr11: got q=%b qbar=%b err=%b expected q=0101 qbar=1010 err=0011", q4, qb4, e4);
        end
        @(negedge clk);
        s4 = 4'b1000;
        r4 = 4'b0001;
        @(posedge clk);
        #1;
        n_checks++;
        if (q4 !== 4'b1100 || qb4 !== 4'b0011 || e4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL w4_independent: got q=%b qbar=%b err=%b expected q=1100 qbar=0011 err=0000", q4, qb4, e4);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        s        = 1'b0;
        r        = 1'b0;
        rst4     = 1'b0;
        s4       = 4'b0000;
        r4       = 4'b0000;
        repeat (2) @(posedge clk);
        test_reset();
        test_hold_reset();
        test_set_hold();
        test_invalid();
        test_async_mid();
        test_multi_bit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
